// File: rtl/clk_supervisor_pkg.sv
//------------------------------------------------------------------------------
// clk_supervisor_pkg : shared clock-state codes, FSM encodings and fault codes
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clk_supervisor_pkg;

    localparam logic [2:0] CLK_STATE_LOW       = 3'd0;
    localparam logic [2:0] CLK_STATE_HIGH      = 3'd1;
    localparam logic [2:0] CLK_STATE_RISE      = 3'd2;
    localparam logic [2:0] CLK_STATE_FALL      = 3'd3;
    localparam logic [2:0] CLK_STATE_UNDIFINED = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } sup_state_e;

    localparam logic [1:0] FAULT_NONE   = 2'd0;
    localparam logic [1:0] FAULT_NO_CLK = 2'd1;
    localparam logic [1:0] FAULT_PERIOD = 2'd2;
    localparam logic [1:0] FAULT_UNDEF  = 2'd3;

    function automatic logic in_window(input int period, input int lo, input int hi);
        return (period >= lo) && (period <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_period_counter.sv
//------------------------------------------------------------------------------
// clk_period_counter : saturating cycles-since-rise counter with timeout flag
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_period_counter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             rise_i,
    output logic [CNT_W-1:0] period_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || rise_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A rise in the timeout cycle takes precedence, so timeout is masked by it.
    assign period_o  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    assign timeout_o = !rise_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/clk_supervisor.sv
//------------------------------------------------------------------------------
// clk_supervisor : monitored-clock period supervisor with lock/fault FSM
// Optional feature macro: CLK_SUPERVISOR_UNDEF_CHECK_EN (undefined state -> fault)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_supervisor #(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 8,
    parameter int MAX_PERIOD = 12,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [2:0]       clk_state_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic [2:0]       state_o,
    output logic             locked_o,
    output logic             fault_o,
    output logic [1:0]       fault_code_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_vld_o
);
    import clk_supervisor_pkg::*;

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    sup_state_e        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [1:0]        code_q, code_d;
    logic              locked_q, fault_q, period_vld_q;
    logic [CNT_W-1:0]  period_q;

    logic              w_rise, w_undef, w_timeout, w_in_win, w_upd, w_cnt_clr;
    logic [CNT_W-1:0]  w_period;

    assign w_rise    = (clk_state_i == CLK_STATE_RISE);
`ifdef CLK_SUPERVISOR_UNDEF_CHECK_EN
    assign w_undef   = (clk_state_i == CLK_STATE_UNDIFINED);
`else
    assign w_undef   = 1'b0;
`endif
    assign w_cnt_clr = (state_q == ST_IDLE) || (state_q == ST_FAULT);

    clk_period_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (w_cnt_clr),
        .rise_i    (w_rise),
        .period_o  (w_period),
        .timeout_o (w_timeout)
    );

    assign w_in_win = in_window(int'(w_period), MIN_PERIOD, MAX_PERIOD);
    // The first rise in ACQUIRE only opens the first full period, so it is not reported.
    assign w_upd    = enable_i && w_rise &&
                      ((state_q == ST_MEASURE) || (state_q == ST_LOCKED));

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        code_d  = code_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
            good_d  = '0;
            code_d  = FAULT_NONE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ACQUIRE;
                ST_ACQUIRE, ST_MEASURE, ST_LOCKED: begin
                    if (w_undef) begin
                        state_d = ST_FAULT;
                        code_d  = FAULT_UNDEF;
                    end else if (w_rise) begin
                        if (state_q == ST_ACQUIRE) begin
                            state_d = ST_MEASURE;
                            good_d  = '0;
                        end else if (!w_in_win) begin
                            if (state_q == ST_LOCKED) begin
                                state_d = ST_FAULT;
                                code_d  = FAULT_PERIOD;
                            end else begin
                                good_d = '0;
                            end
                        end else if (state_q == ST_MEASURE) begin
                            good_d = good_q + GOOD_W'(1);
                            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else if (w_timeout) begin
                        state_d = ST_FAULT;
                        code_d  = FAULT_NO_CLK;
                    end
                end
                ST_FAULT: begin
                    if (clear_i) begin
                        state_d = ST_ACQUIRE;
                        code_d  = FAULT_NONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            good_q       <= '0;
            code_q       <= FAULT_NONE;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            code_q       <= code_d;
            locked_q     <= (state_d == ST_LOCKED);
            fault_q      <= (state_d == ST_FAULT);
            period_vld_q <= w_upd;
            if (w_upd) begin
                period_q <= w_period;
            end
        end
    end

    assign state_o      = state_q;
    assign locked_o     = locked_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;
    assign period_o     = period_q;
    assign period_vld_o = period_vld_q;

endmodule

`default_nettype wire
